// File: rtl/coram_seq_writer_pkg.sv
// Shared types and field positions for the CoRAM sequence writer.
// The optional readback check is enabled by CORAM_SEQ_WRITER_READBACK_EN.
package coram_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W0,
    CMD1,
    W1,
    FILL,
    VERIFY,
    REPLY,
    WR
  } state_e;

  localparam int LEN_LSB  = 0;
  localparam int LEN_W    = 16;
  localparam int STEP_LSB = 16;
  localparam int STEP_W   = 16;

  localparam int REPLY_N_LSB   = 0;
  localparam int REPLY_N_W     = 16;
  localparam int REPLY_ERR_LSB = 16;
  localparam int REPLY_ERR_W   = 16;

  function automatic logic [REPLY_ERR_W-1:0] satInc(input logic [REPLY_ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/coram_seq_writer_if.sv
// Memory port and channel bundle between the writer and its CoRAM memory/channel.
interface coram_seq_writer_if
  import coram_seq_pkg::*;
#(
  parameter int W_A = 10,
  parameter int W_D = 32
);
  logic [W_A-1:0] mem_addr;
  logic [W_D-1:0] mem_d;
  logic           mem_we;
  logic [W_D-1:0] mem_q;
  logic [W_D-1:0] comm_d;
  logic           comm_enq;
  logic           comm_full;
  logic [W_D-1:0] comm_q;
  logic           comm_deq;
  logic           comm_empty;

  modport master (
    output mem_addr, mem_d, mem_we, comm_d, comm_enq, comm_deq,
    input  mem_q, comm_full, comm_q, comm_empty
  );

  modport slave (
    input  mem_addr, mem_d, mem_we, comm_d, comm_enq, comm_deq,
    output mem_q, comm_full, comm_q, comm_empty
  );
endinterface

// File: rtl/coram_seq_writer_gen.sv
// Arithmetic sequence generator: running value plus word index with a last-word flag.
module coram_seq_gen
  import coram_seq_pkg::*;
#(
  parameter int W_A = 10,
  parameter int W_D = 32
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           load_i,
  input  logic           advance_i,
  input  logic [W_D-1:0] base_i,
  input  logic [W_D-1:0] step_i,
  input  logic [W_A:0]   count_i,
  output logic [W_D-1:0] acc_o,
  output logic [W_A-1:0] idx_o,
  output logic           last_o
);
  logic [W_D-1:0] acc_q;
  logic [W_D-1:0] step_q;
  logic [W_A-1:0] idx_q;

  // load wins over advance so a sequence can restart on its own final word
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q  <= '0;
      step_q <= '0;
      idx_q  <= '0;
    end else if (load_i) begin
      acc_q  <= base_i;
      step_q <= step_i;
      idx_q  <= '0;
    end else if (advance_i) begin
      acc_q <= acc_q + step_q;
      idx_q <= idx_q + 1'b1;
    end
  end

  assign acc_o  = acc_q;
  assign idx_o  = idx_q;
  assign last_o = ({1'b0, idx_q} + (W_A+1)'(1)) == count_i;
endmodule

// File: rtl/coram_seq_writer.sv
// CoRAM producer: takes a {base, len/step} command, fills memory with a sequence, replies n.
// Define CORAM_SEQ_WRITER_READBACK_EN to re-read and count mismatches before replying.
module coram_seq_writer
  import coram_seq_pkg::*;
#(
  parameter int W_A      = 10,
  parameter int W_COMM_A = 4,
  parameter int W_D      = 32,
  parameter int SIZE     = 128
) (
  input  logic                CLK,
  input  logic                RST,
  coram_seq_writer_if.master  bus,
  output logic                busy,
  output logic [15:0]         last_count
);
  if (W_D < 32 || SIZE < 1 || SIZE > (1 << W_A) || W_COMM_A < 1) begin : gBadParams
    $error("coram_seq_writer: illegal parameter combination");
  end

  state_e         state_q;
  logic [W_D-1:0] base_q;
  logic [15:0]    len_q;
  logic [W_D-1:0] step_q;
  logic [W_A:0]   n_q;
  logic [W_A:0]   n_d;
  logic [W_A-1:0] mem_addr_q;
  logic [W_D-1:0] mem_d_q;
  logic           mem_we_q;
  logic [W_D-1:0] comm_d_q;
  logic           comm_enq_q;
  logic           comm_deq_q;
  logic           busy_q;
  logic [15:0]    last_count_q;
  logic [W_D-1:0] reply_d;

  logic [W_D-1:0] genAcc;
  logic [W_A-1:0] genIdx;
  logic           genLast;
  logic           genLoad;
  logic           genAdvance;

`ifdef CORAM_SEQ_WRITER_READBACK_EN
  logic                   vAct_q;
  logic                   chk_q;
  logic [W_D-1:0]         exp_q;
  logic [REPLY_ERR_W-1:0] err_q;

  assign genLoad    = (state_q == W1) || (state_q == FILL && genLast);
  assign genAdvance = (state_q == FILL) || (state_q == VERIFY && vAct_q);
  assign reply_d    = W_D'({err_q, REPLY_N_W'(n_q)});
`else
  assign genLoad    = (state_q == W1);
  assign genAdvance = (state_q == FILL);
  assign reply_d    = W_D'(REPLY_N_W'(n_q));
`endif

  assign n_d = (32'(len_q) > SIZE) ? (W_A+1)'(SIZE) : (W_A+1)'(len_q);

  coram_seq_gen #(.W_A(W_A), .W_D(W_D)) u_gen (
    .CLK       (CLK),
    .RST       (RST),
    .load_i    (genLoad),
    .advance_i (genAdvance),
    .base_i    (base_q),
    .step_i    (step_q),
    .count_i   (n_q),
    .acc_o     (genAcc),
    .idx_o     (genIdx),
    .last_o    (genLast)
  );

  // Channel strobes are one-cycle pulses; W0/W1/WR give the FIFO flags a cycle to settle
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      base_q       <= '0;
      len_q        <= '0;
      step_q       <= '0;
      n_q          <= '0;
      mem_addr_q   <= '0;
      mem_d_q      <= '0;
      mem_we_q     <= 1'b0;
      comm_d_q     <= '0;
      comm_enq_q   <= 1'b0;
      comm_deq_q   <= 1'b0;
      busy_q       <= 1'b0;
      last_count_q <= '0;
`ifdef CORAM_SEQ_WRITER_READBACK_EN
      vAct_q       <= 1'b0;
      chk_q        <= 1'b0;
      exp_q        <= '0;
      err_q        <= '0;
`endif
    end else begin
      comm_deq_q <= 1'b0;
      comm_enq_q <= 1'b0;
      mem_we_q   <= 1'b0;
      case (state_q)
        IDLE: if (!bus.comm_empty) begin
          comm_deq_q <= 1'b1;
          base_q     <= bus.comm_q;
          busy_q     <= 1'b1;
          state_q    <= W0;
        end
        W0: state_q <= CMD1;
        CMD1: if (!bus.comm_empty) begin
          comm_deq_q <= 1'b1;
          len_q      <= bus.comm_q[LEN_LSB +: LEN_W];
          step_q     <= W_D'(bus.comm_q[STEP_LSB +: STEP_W]);
          state_q    <= W1;
        end
        W1: begin
          n_q     <= n_d;
          state_q <= (n_d == '0) ? REPLY : FILL;
`ifdef CORAM_SEQ_WRITER_READBACK_EN
          err_q   <= '0;
`endif
        end
        FILL: begin
          mem_we_q   <= 1'b1;
          mem_addr_q <= genIdx;
          mem_d_q    <= genAcc;
          if (genLast) begin
`ifdef CORAM_SEQ_WRITER_READBACK_EN
            vAct_q  <= 1'b1;
            chk_q   <= 1'b0;
            state_q <= VERIFY;
`else
            state_q <= REPLY;
`endif
          end
        end
`ifdef CORAM_SEQ_WRITER_READBACK_EN
        // exp_q trails the issued address by one cycle to line up with mem_q
        VERIFY: begin
          if (chk_q && bus.mem_q != exp_q) err_q <= satInc(err_q);
          if (vAct_q) begin
            mem_addr_q <= genIdx;
            exp_q      <= genAcc;
            chk_q      <= 1'b1;
            if (genLast) vAct_q <= 1'b0;
          end else begin
            chk_q   <= 1'b0;
            state_q <= REPLY;
          end
        end
`endif
        REPLY: if (!bus.comm_full) begin
          comm_enq_q <= 1'b1;
          comm_d_q   <= reply_d;
          state_q    <= WR;
        end
        WR: begin
          busy_q       <= 1'b0;
          last_count_q <= 16'(n_q);
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_d    = mem_d_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.comm_d   = comm_d_q;
  assign bus.comm_enq = comm_enq_q;
  assign bus.comm_deq = comm_deq_q;
  assign busy         = busy_q;
  assign last_count   = last_count_q;
endmodule

// File: tb/tb_coram_seq_writer.sv
// Directed bench for coram_seq_writer: models the command channel and memory,
// logs every write/dequeue/reply, and compares against hand-computed expectations.
module tb_coram_seq_writer;
  import coram_seq_pkg::*;

  localparam int W_A  = 10;
  localparam int W_D  = 32;
  localparam int SIZE = 128;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        busy;
  logic [15:0] last_count;

  always #5 CLK = ~CLK;

  coram_seq_writer_if #(.W_A(W_A), .W_D(W_D)) bus ();

  coram_seq_writer #(.W_A(W_A), .W_COMM_A(4), .W_D(W_D), .SIZE(SIZE)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus),
    .busy       (busy),
    .last_count (last_count)
  );

  logic [31:0] cmdMem [0:63];
  logic [5:0]  cmdHead = '0;
  logic [5:0]  cmdTail = '0;
  logic        commFull = 1'b0;
  logic [31:0] memArr [0:1023];

  assign bus.comm_empty = (cmdHead == cmdTail);
  assign bus.comm_q     = cmdMem[cmdHead];
  assign bus.comm_full  = commFull;
  assign bus.mem_q      = memArr[bus.mem_addr];

  int          cycle = 0;
  int          wrCount = 0;
  int          repCount = 0;
  int          deqCount = 0;
  logic [9:0]  wrAddr [0:511];
  logic [31:0] wrData [0:511];
  int          wrCycle [0:511];
  logic [31:0] repData [0:31];
  int          repCycle [0:31];
  int          deqCycle [0:63];

  int checks = 0;
  int errors = 0;

  always @(posedge CLK) cycle++;

  always @(negedge CLK) begin
    if (bus.comm_deq) begin
      deqCycle[deqCount] = cycle;
      deqCount++;
      cmdHead = cmdHead + 1'b1;
    end
    if (bus.mem_we) begin
      wrAddr[wrCount]  = bus.mem_addr;
      wrData[wrCount]  = bus.mem_d;
      wrCycle[wrCount] = cycle;
      memArr[bus.mem_addr] = bus.mem_d;
      wrCount++;
    end
    if (bus.comm_enq) begin
      repData[repCount]  = bus.comm_d;
      repCycle[repCount] = cycle;
      repCount++;
    end
  end

  typedef struct {
    string       name;
    logic [31:0] base;
    logic [15:0] len;
    logic [15:0] step;
    int          expN;
    logic [31:0] expLast;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] base, input logic [15:0] len, input logic [15:0] step);
    cmdMem[cmdTail] = base;
    cmdTail = cmdTail + 1'b1;
    cmdMem[cmdTail] = {step, len};
    cmdTail = cmdTail + 1'b1;
  endtask

  task automatic waitReplies(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge CLK);
      #1;
      if (repCount >= target) ok = 1'b1;
    end
  endtask

  task automatic runVector(input vec_t v);
    int          wr0, rep0, deq0, bad;
    bit          ok;
    logic [31:0] expD;
    wr0  = wrCount;
    rep0 = repCount;
    deq0 = deqCount;
    applyStimulus(v.base, v.len, v.step);
    waitReplies(rep0 + 1, 2000, ok);
    checkOutput({v.name, "_done"}, 32'(ok), 32'd1);
    @(negedge CLK);
    #1;
    if (ok) checkOutput({v.name, "_reply"}, repData[rep0], 32'(v.expN));
    checkOutput({v.name, "_nwrites"}, 32'(wrCount - wr0), 32'(v.expN));
    bad = 0;
    for (int j = 0; j < v.expN && j < wrCount - wr0; j++) begin
      expD = v.base + 32'(j) * {16'h0, v.step};
      if (wrAddr[wr0+j] != 10'(j) || wrData[wr0+j] != expD) bad++;
      if (j > 0 && wrCycle[wr0+j] != wrCycle[wr0+j-1] + 1) bad++;
    end
    checkOutput({v.name, "_seq_bad"}, 32'(bad), 32'd0);
    if (v.expN > 0 && wrCount - wr0 == v.expN) begin
      checkOutput({v.name, "_lastdata"}, wrData[wrCount-1], v.expLast);
      checkOutput({v.name, "_latency"}, 32'(wrCycle[wr0]), 32'(deqCycle[deq0+1] + 2));
    end
    checkOutput({v.name, "_last_count"}, 32'(last_count), 32'(v.expN));
    checkOutput({v.name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int  wr0, rep0, dropCycle;
    bit  ok;

    vecs[0] = '{"basic",   32'h0000_0100, 16'd4,   16'd3,      4,   32'h0000_0109};
    vecs[1] = '{"len0",    32'h0000_0055, 16'd0,   16'd7,      0,   32'h0};
    vecs[2] = '{"clamp",   32'h0000_0000, 16'd200, 16'd1,      128, 32'h0000_007F};
    vecs[3] = '{"wrap",    32'hFFFF_FFFE, 16'd3,   16'd1,      3,   32'h0000_0000};
    vecs[4] = '{"step0",   32'h0000_ABCD, 16'd5,   16'd0,      5,   32'h0000_ABCD};
    vecs[5] = '{"bigstep", 32'h0000_0010, 16'd2,   16'hFFFF,   2,   32'h0001_000F};
    vecs[6] = '{"exact",   32'h0000_0007, 16'd128, 16'd2,      128, 32'h0000_0105};

    repeat (3) @(negedge CLK);
    #1;
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst_comm_deq", 32'(bus.comm_deq), 32'd0);
    checkOutput("rst_comm_enq", 32'(bus.comm_enq), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_last_count", 32'(last_count), 32'd0);
    RST = 1'b0;

    for (int i = 0; i < 7; i++) runVector(vecs[i]);

    // Reply must stall while the channel is full, then fire exactly once
    commFull = 1'b1;
    wr0  = wrCount;
    rep0 = repCount;
    applyStimulus(32'h20, 16'd2, 16'd1);
    repeat (40) @(negedge CLK);
    #1;
    checkOutput("stall_noenq", 32'(repCount - rep0), 32'd0);
    checkOutput("stall_busy", 32'(busy), 32'd1);
    checkOutput("stall_writes", 32'(wrCount - wr0), 32'd2);
    commFull  = 1'b0;
    dropCycle = cycle;
    waitReplies(rep0 + 1, 50, ok);
    checkOutput("stall_done", 32'(ok), 32'd1);
    if (ok) begin
      checkOutput("stall_enq_cycle", 32'(repCycle[rep0]), 32'(dropCycle + 1));
      checkOutput("stall_reply", repData[rep0], 32'd2);
    end
    repeat (10) @(negedge CLK);
    #1;
    checkOutput("stall_one_reply", 32'(repCount - rep0), 32'd1);

    // Second command waits in the channel until the first completes
    wr0  = wrCount;
    rep0 = repCount;
    applyStimulus(32'h1, 16'd2, 16'd1);
    applyStimulus(32'h2, 16'd3, 16'd2);
    waitReplies(rep0 + 2, 300, ok);
    checkOutput("queue_done", 32'(ok), 32'd1);
    if (ok) begin
      checkOutput("queue_reply_a", repData[rep0], 32'd2);
      checkOutput("queue_reply_b", repData[rep0+1], 32'd3);
    end
    checkOutput("queue_nwrites", 32'(wrCount - wr0), 32'd5);
    if (wrCount - wr0 == 5) begin
      checkOutput("queue_b_first", wrData[wr0+2], 32'd2);
      checkOutput("queue_b_last", wrData[wr0+4], 32'd6);
    end
    repeat (2) @(negedge CLK);

    // Reset on the third fill write aborts without a reply
    wr0 = wrCount;
    applyStimulus(32'h0, 16'd10, 16'd1);
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge CLK);
      #1;
      if (wrCount >= wr0 + 3) ok = 1'b1;
    end
    checkOutput("mid_third_write", 32'(ok), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    #1;
    checkOutput("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("mid_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("mid_rst_mem_d", bus.mem_d, 32'd0);
    checkOutput("mid_rst_comm_d", bus.comm_d, 32'd0);
    checkOutput("mid_rst_strobes", 32'({bus.comm_enq, bus.comm_deq}), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_last_count", 32'(last_count), 32'd0);
    RST  = 1'b0;
    rep0 = repCount;
    repeat (40) @(negedge CLK);
    #1;
    checkOutput("mid_rst_noreply", 32'(repCount - rep0), 32'd0);
    checkOutput("mid_rst_writes", 32'(wrCount - wr0), 32'd3);
    runVector(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
